mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage front end of the pipelined core; produces MemDataM, the load data registered into the MEM/WB stage.
- Converts byte, halfword and word loads and stores into accesses on a word-aligned data-memory port with a req/ready handshake.
- Splits misaligned accesses into two word beats.
- Stalls the pipeline through StallM until the access completes.

Parameters:
- DATA_WIDTH, 32, datapath and memory word width; only 32 is supported.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- MemReadM  in  1  load in MEM stage
- MemWriteM  in  1  store in MEM stage
- Funct3M  in  3  load/store size and sign code
- ALUResultM  in  ADDR_WIDTH  byte address
- WriteDataM  in  DATA_WIDTH  store data, right-justified
- MemDataM  out  DATA_WIDTH  extended load data, valid in DONE
- StallM  out  1  holds IF/ID/EX/MEM stages
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  ADDR_WIDTH  word address, bits [1:0] always 0
- mem_wdata  out  DATA_WIDTH  lane-rotated store data
- mem_wstrb  out  4  byte strobes
- mem_ready  in  1  request accepted; mem_rdata valid this cycle
- mem_rdata  in  DATA_WIDTH  read word

Behaviour:
- Clock and reset: rst is synchronous and active-high. On reset: state=IDLE, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, MemDataM=0, StallM=0, beat-0 holding register=0.
- Sizes and offsets: off = ALUResultM[1:0]. Size is B (funct3 000/100), H (001/101) or W (010). Sign extension applies to 000 and 001 only.
- Illegal funct3 (011, 110, 111), or funct3 100/101 on a store: no access, no stall, MemDataM=0.
- Split rule: an access splits when off+bytes>4, i.e. H at off 3, or W at off 1..3.
- State IDLE:
  - StallM = (MemReadM|MemWriteM) & legal, combinational.
  - Next state is BEAT0 if that term is true.
  - Address, data, size and we are latched into internal registers. Pipeline inputs are ignored after IDLE.
- State BEAT0:
  - mem_req=1; mem_addr = {addr[31:2],2'b00}.
  - mem_wdata = data rotated left by off*8.
  - mem_wstrb = (size mask << off) truncated to 4 bits.
  - StallM=1.
  - On mem_ready: capture mem_rdata into rdata0, then go to BEAT1 if split, else DONE.
  - Without mem_ready: hold all request outputs stable.
- State BEAT1:
  - mem_addr = first word address + 4. This wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).
  - mem_wstrb = size mask >> (4-off).
  - mem_wdata uses the same rotation as BEAT0.
  - StallM=1. On mem_ready: capture rdata1, then go to DONE.
- State DONE:
  - mem_req=0 and StallM=0, so the pipeline advances at the end of this cycle.
  - MemDataM = extend(({rdata1,rdata0} >> off*8) masked to size).
  - Next state is IDLE. The same instruction is never retriggered.
  - Stores also pass through DONE, with MemDataM=0.
- Minimum latency: 3 cycles for an aligned access with immediate ready; 4 cycles for a split access.
- Outputs in IDLE and DONE: mem_req=0, mem_wstrb=0.
- Write gating: mem_we equals the latched store flag while mem_req=1, and is 0 otherwise.
- Reset asserted mid-access: return to IDLE next cycle and drop mem_req. The memory must tolerate an abandoned request.
- Simultaneous MemReadM and MemWriteM: treated as a store.

Decomposition:
- Package mem_access_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state enum mau_state_t {IDLE, BEAT0, BEAT1, DONE};
  - a size-mask function.
- Sub-module load_align_extend: combinational. Takes the 64-bit pair, off and funct3, and returns MemDataM.

Test Plan:
- LW at 0x100, mem_rdata=0xDEADBEEF, ready immediate -> one beat at addr 0x100, wstrb 0, MemDataM=0xDEADBEEF in DONE, StallM high for 2 cycles.
- LB at 0x103 with word 0x80FF_0000 -> MemDataM=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH data 0x1234 at 0x106 -> addr 0x104, wstrb 4'b1100, wdata 0x12340000, mem_we=1.
- LW at 0x101, words 0x44332211 then 0x88776655 -> two beats at 0x100 and 0x104, MemDataM=0x55443322.
- SW 0xAABBCCDD at 0xFFFFFFFE -> beat0 addr 0xFFFFFFFC wstrb 1100; beat1 addr 0x00000000 wstrb 0011; wdata 0xCCDDAABB both beats.
- mem_ready held low 5 cycles in BEAT0, then rst asserted -> request outputs stable while waiting; after reset, IDLE with mem_req=0, StallM=0, MemDataM=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-stage access unit.
//   - funct3 load/store size codes
//   - mau_state_t: sequencing of one access (IDLE, BEAT0, BEAT1, DONE)
//   - helpers for the byte-lane mask, legality, split detection and
//     lane rotation of store data
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } mau_state_t;

    // Right-justified byte mask for the access size.
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: size_mask = 4'b0001;
            F3_H, F3_HU: size_mask = 4'b0011;
            F3_W:        size_mask = 4'b1111;
            default:     size_mask = 4'b0000;
        endcase
    endfunction

    // Unsigned variants exist only for loads.
    function automatic logic f3_legal(input logic [2:0] funct3, input logic is_store);
        case (funct3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = ~is_store;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

    // An access needs a second word when off + bytes > 4.
    function automatic logic is_split(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_H, F3_HU: is_split = (off == 2'd3);
            F3_W:        is_split = (off != 2'd0);
            default:     is_split = 1'b0;
        endcase
    endfunction

    // Rotate left by off bytes so data byte 0 lands on lane off.
    function automatic logic [31:0] rotl_bytes(input logic [31:0] data, input logic [1:0] off);
        logic [63:0] dbl;
        dbl = {data, data} << {off, 3'b000};
        return dbl[63:32];
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align_extend.sv
// load_align_extend: combinational load data alignment.
//   pair   - {second word, first word} as read from memory
//   off    - byte offset of the access within the first word
//   funct3 - load size / sign code
//   data   - right-justified, sign- or zero-extended load result
//            (zero for any code that is not a load size)
module load_align_extend
    import mem_access_pkg::*;
(
    input  logic [63:0] pair,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    // Bytes past the access fall off the top; only the low 32 bits matter.
    assign shifted = 32'(pair >> {off, 3'b000});

    always_comb begin
        // NOTE: default first so every path assigns data; otherwise a latch is inferred.
        data = '0;
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   data = {24'd0, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   data = {16'd0, shifted[15:0]};
            F3_W:    data = shifted;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage front end of the pipelined core.
// Turns byte/halfword/word loads and stores into word-aligned beats on a
// req/ready memory port, splitting misaligned accesses into two beats,
// and stalls the pipeline until the access completes.
//   clk, rst        - clock, synchronous active-high reset
//   MemReadM        - load in MEM stage
//   MemWriteM       - store in MEM stage (wins over MemReadM)
//   Funct3M         - size / sign code
//   ALUResultM      - byte address
//   WriteDataM      - right-justified store data
//   MemDataM        - extended load data, valid in DONE, else 0
//   StallM          - holds IF/ID/EX/MEM while the access is in flight
//   mem_req/mem_we  - memory request and write enable
//   mem_addr        - word address (bits [1:0] always 0)
//   mem_wdata       - lane-rotated store data
//   mem_wstrb       - byte strobes (stores only)
//   mem_ready       - request accepted, mem_rdata valid this cycle
//   mem_rdata       - read word
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [2:0]            Funct3M,
    input  logic [ADDR_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic [DATA_WIDTH-1:0] MemDataM,
    output logic                  StallM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    mau_state_t            state;
    logic [1:0]            off_q;
    logic [2:0]            f3_q;
    logic                  we_q;
    logic                  split_q;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic [DATA_WIDTH-1:0] aligned;
    logic                  is_store;
    logic                  start;

    assign is_store = MemWriteM;
    assign start    = (MemReadM | MemWriteM) & f3_legal(Funct3M, is_store);

    // Stall is raised combinationally in IDLE so the instruction is held
    // the same cycle it is recognised.
    always_comb begin
        case (state)
            IDLE:         StallM = start & ~rst;
            BEAT0, BEAT1: StallM = 1'b1;
            default:      StallM = 1'b0;
        endcase
    end

    load_align_extend u_align (
        .pair   ({rdata1, rdata0}),
        .off    (off_q),
        .funct3 (f3_q),
        .data   (aligned)
    );

    assign MemDataM = (state == DONE && !we_q) ? aligned : '0;

    // Request outputs are registered and set up one state ahead, so they
    // stay stable for as long as mem_ready is low.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            off_q     <= '0;
            f3_q      <= '0;
            we_q      <= 1'b0;
            split_q   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= BEAT0;
                        off_q     <= ALUResultM[1:0];
                        f3_q      <= Funct3M;
                        we_q      <= is_store;
                        split_q   <= is_split(Funct3M, ALUResultM[1:0]);
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata <= rotl_bytes(WriteDataM, ALUResultM[1:0]);
                        mem_wstrb <= is_store ? (size_mask(Funct3M) << ALUResultM[1:0]) : 4'b0000;
                    end
                end
                BEAT0: begin
                    if (mem_ready) begin
                        rdata0 <= mem_rdata;
                        if (split_q) begin
                            state     <= BEAT1;
                            // Wraps modulo 2^ADDR_WIDTH at the top of memory.
                            mem_addr  <= mem_addr + ADDR_WIDTH'(4);
                            mem_wstrb <= we_q ? (size_mask(f3_q) >> (3'd4 - {1'b0, off_q})) : 4'b0000;
                        end else begin
                            state     <= DONE;
                            mem_req   <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_wstrb <= 4'b0000;
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ready) begin
                        rdata1    <= mem_rdata;
                        state     <= DONE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'b0000;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. A byte-addressed reference
// memory predicts every beat and every load result; a word-level memory
// responder answers the DUT; a monitor compares beats and DONE cycles
// against a scoreboard queue filled by the stimulus process.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemReadM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [2:0]  Funct3M = 3'd0;
    logic [31:0] ALUResultM = 32'd0;
    logic [31:0] WriteDataM = 32'd0;
    logic [31:0] MemDataM;
    logic        StallM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .MemDataM   (MemDataM),
        .StallM     (StallM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        bit        is_done;
        bit [31:0] addr;
        bit        we;
        bit [3:0]  strb;
        bit [31:0] wdata;
        bit [31:0] data;
    } exp_t;

    exp_t      sb_q[$];
    bit [31:0] word_mem [bit [31:0]];
    bit [7:0]  ref_mem  [bit [31:0]];

    int n_checks = 0;
    int n_pass = 0;
    int done_count = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: never
    int stall_run = 0;
    int last_stall = 0;
    int beat_idx = 0;
    int last_beats = 0;
    bit [31:0] last_data;
    bit [31:0] log_addr [2];
    bit [3:0]  log_strb [2];
    bit [31:0] log_wdata[2];
    bit        log_we   [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    function automatic bit [31:0] init_word(input bit [31:0] a);
        return a * 32'h9E37_79B1;
    endfunction

    function automatic bit [31:0] get_word(input bit [31:0] a);
        if (word_mem.exists(a)) return word_mem[a];
        return init_word(a);
    endfunction

    function automatic bit [7:0] ref_byte(input bit [31:0] a);
        bit [31:0] w;
        if (ref_mem.exists(a)) return ref_mem[a];
        w = init_word({a[31:2], 2'b00}) >> {a[1:0], 3'b000};
        return w[7:0];
    endfunction

    task automatic poke_word(input bit [31:0] a, input bit [31:0] w);
        word_mem[a] = w;
        for (int k = 0; k < 4; k++) ref_mem[a + 32'(k)] = w[8*k +: 8];
    endtask

    // Memory responder: drives ready/rdata just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_req && !rst) begin
                case (ready_mode)
                    0:       mem_ready = 1'b1;
                    1:       mem_ready = ($urandom_range(0, 2) != 0);
                    default: mem_ready = 1'b0;
                endcase
                mem_rdata = mem_ready ? get_word(mem_addr) : $urandom;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: accepted beats and the DONE cycle that follows the last one.
    initial begin
        bit   prev_acc;
        exp_t e;
        bit [31:0] w;
        prev_acc = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_acc = 1'b0;
                stall_run = 0;
                beat_idx = 0;
                continue;
            end
            if (StallM) stall_run++;
            if (mem_req && mem_ready) begin
                if (sb_q.size() == 0) fail_now("unexpected_beat");
                else begin
                    e = sb_q.pop_front();
                    if (e.is_done) fail_now("beat_where_done_expected");
                    else begin
                        check("beat_addr", mem_addr, e.addr);
                        check("beat_we", mem_we, e.we);
                        check("beat_wstrb", mem_wstrb, e.strb);
                        if (e.we) check("beat_wdata", mem_wdata, e.wdata);
                        check("beat_stall", StallM, 1);
                    end
                end
                if (beat_idx < 2) begin
                    log_addr[beat_idx]  = mem_addr;
                    log_strb[beat_idx]  = mem_wstrb;
                    log_wdata[beat_idx] = mem_wdata;
                    log_we[beat_idx]    = mem_we;
                end
                beat_idx++;
                if (mem_we) begin
                    w = get_word(mem_addr);
                    for (int k = 0; k < 4; k++)
                        if (mem_wstrb[k]) w[8*k +: 8] = mem_wdata[8*k +: 8];
                    word_mem[mem_addr] = w;
                end
            end else if (prev_acc && !mem_req) begin
                if (sb_q.size() == 0) fail_now("unexpected_done");
                else begin
                    e = sb_q.pop_front();
                    if (!e.is_done) fail_now("done_where_beat_expected");
                    else begin
                        check("done_memdata", MemDataM, e.data);
                        check("done_stall", StallM, 0);
                        check("done_wstrb", mem_wstrb, 0);
                        check("done_we", mem_we, 0);
                    end
                end
                last_data  = MemDataM;
                last_stall = stall_run;
                last_beats = beat_idx;
                stall_run  = 0;
                beat_idx   = 0;
                done_count++;
            end
            prev_acc = mem_req && mem_ready;
        end
    end

    // Issue one instruction, predict its beats and result, wait for DONE.
    task automatic issue(input bit rd, input bit wr, input bit [2:0] f3,
                         input bit [31:0] a, input bit [31:0] d);
        bit        store;
        bit        legal;
        int        n;
        int        nb;
        int        lane;
        int        target;
        int        cyc;
        bit [31:0] first;
        bit [31:0] ba;
        bit [31:0] v;
        exp_t      e;
        store = wr;
        if (store) legal = (f3 inside {3'd0, 3'd1, 3'd2});
        else       legal = rd && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        @(negedge clk);
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = a; WriteDataM = d;
        if (!legal) begin
            #2;
            check("noacc_stall", StallM, 0);
            check("noacc_memdata", MemDataM, 0);
            @(posedge clk);
            #1;
            check("noacc_req", mem_req, 0);
            MemReadM = 1'b0; MemWriteM = 1'b0;
            return;
        end
        n     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        first = {a[31:2], 2'b00};
        nb    = (int'(a[1:0]) + n > 4) ? 2 : 1;
        for (int b = 0; b < nb; b++) begin
            e.is_done = 1'b0;
            e.addr    = first + 32'(4 * b);
            e.we      = store;
            e.strb    = 4'b0000;
            e.wdata   = 32'd0;
            e.data    = 32'd0;
            if (store)
                for (int k = 0; k < n; k++) begin
                    ba = a + 32'(k);
                    if ({ba[31:2], 2'b00} == e.addr) e.strb[ba[1:0]] = 1'b1;
                end
            for (int k = 0; k < 4; k++) begin
                lane = (int'(a[1:0]) + k) % 4;
                e.wdata[8*lane +: 8] = d[8*k +: 8];
            end
            sb_q.push_back(e);
        end
        e.is_done = 1'b1;
        e.addr = 32'd0; e.we = 1'b0; e.strb = 4'b0000; e.wdata = 32'd0;
        if (store) begin
            for (int k = 0; k < n; k++) ref_mem[a + 32'(k)] = d[8*k +: 8];
            e.data = 32'd0;
        end else begin
            v = 32'd0;
            for (int k = 0; k < n; k++) v[8*k +: 8] = ref_byte(a + 32'(k));
            if (f3 == 3'b000 && v[7])  v[31:8]  = 24'hFF_FFFF;
            if (f3 == 3'b001 && v[15]) v[31:16] = 16'hFFFF;
            e.data = v;
        end
        sb_q.push_back(e);
        target = done_count + 1;
        cyc = 0;
        while (done_count < target && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        MemReadM = 1'b0; MemWriteM = 1'b0;
        if (done_count < target) begin
            fail_now("access_timeout");
            sb_q.delete();
        end
    endtask

    initial begin
        #500000;
        fail_now("watchdog");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #2;
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_wstrb", mem_wstrb, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_memdata", MemDataM, 0);
        check("rst_stall", StallM, 0);

        // Aligned word load, immediate ready.
        ready_mode = 0;
        poke_word(32'h100, 32'hDEAD_BEEF);
        issue(1'b1, 1'b0, 3'b010, 32'h100, 32'd0);
        check("lw_data", last_data, 32'hDEAD_BEEF);
        check("lw_stall_cycles", last_stall, 2);
        check("lw_beats", last_beats, 1);
        check("lw_addr", log_addr[0], 32'h100);
        check("lw_wstrb", log_strb[0], 0);

        // Signed and unsigned byte at offset 3.
        poke_word(32'h100, 32'h80FF_0000);
        issue(1'b1, 1'b0, 3'b000, 32'h103, 32'd0);
        check("lb_data", last_data, 32'hFFFF_FF80);
        issue(1'b1, 1'b0, 3'b100, 32'h103, 32'd0);
        check("lbu_data", last_data, 32'h0000_0080);

        // Halfword store at offset 2.
        issue(1'b0, 1'b1, 3'b001, 32'h106, 32'h0000_1234);
        check("sh_addr", log_addr[0], 32'h104);
        check("sh_wstrb", log_strb[0], 4'b1100);
        check("sh_wdata", log_wdata[0], 32'h1234_0000);
        check("sh_we", log_we[0], 1);

        // Misaligned word load spanning two words.
        poke_word(32'h100, 32'h4433_2211);
        poke_word(32'h104, 32'h8877_6655);
        issue(1'b1, 1'b0, 3'b010, 32'h101, 32'd0);
        check("lw_split_data", last_data, 32'h5544_3322);
        check("lw_split_beats", last_beats, 2);
        check("lw_split_stall", last_stall, 3);
        check("lw_split_addr1", log_addr[1], 32'h104);

        // Split store wrapping past the top of the address space.
        issue(1'b0, 1'b1, 3'b010, 32'hFFFF_FFFE, 32'hAABB_CCDD);
        check("sw_wrap_addr0", log_addr[0], 32'hFFFF_FFFC);
        check("sw_wrap_strb0", log_strb[0], 4'b1100);
        check("sw_wrap_addr1", log_addr[1], 32'h0000_0000);
        check("sw_wrap_strb1", log_strb[1], 4'b0011);
        check("sw_wrap_wdata0", log_wdata[0], 32'hCCDD_AABB);
        check("sw_wrap_wdata1", log_wdata[1], 32'hCCDD_AABB);
        issue(1'b1, 1'b0, 3'b010, 32'hFFFF_FFFE, 32'd0);
        check("lw_wrap_data", last_data, 32'hAABB_CCDD);

        // Simultaneous read and write behaves as a store; illegal codes do nothing.
        issue(1'b1, 1'b1, 3'b000, 32'h201, 32'h0000_00C3);
        issue(1'b1, 1'b0, 3'b100, 32'h201, 32'd0);
        check("rdwr_store_byte", last_data, 32'h0000_00C3);
        issue(1'b1, 1'b0, 3'b011, 32'h200, 32'd0);
        issue(1'b0, 1'b1, 3'b101, 32'h200, 32'd0);

        // Memory never ready: request held stable, then reset abandons it.
        ready_mode = 2;
        @(negedge clk);
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h304;
        @(posedge clk);
        #1 MemReadM = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            check("wait_req", mem_req, 1);
            check("wait_addr", mem_addr, 32'h304);
            check("wait_wstrb", mem_wstrb, 0);
            check("wait_stall", StallM, 1);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #2;
        check("abort_req", mem_req, 0);
        check("abort_stall", StallM, 0);
        check("abort_memdata", MemDataM, 0);
        check("abort_we", mem_we, 0);
        check("abort_wstrb", mem_wstrb, 0);

        // Random traffic with random ready delays.
        ready_mode = 1;
        for (int i = 0; i < 120; i++) begin
            bit        rd;
            bit        wr;
            bit [2:0]  f3;
            bit [31:0] a;
            rd = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 2) == 0);
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            else                           a = 32'h0000_0200 + 32'($urandom_range(0, 23));
            issue(rd, wr, f3, a, $urandom);
        end

        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
